// File: rtl/dispatch_pkg.sv
// ============================================================================
// Module      : dispatch_pkg
// Description : Shared types and defaults for the kernel dispatch arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dispatch_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam int DEFAULT_NUM_REQ     = 4;
    localparam int DEFAULT_N_W         = 6;
    localparam int DEFAULT_D_W         = 32;
    localparam int DEFAULT_TIMEOUT_CYC = 1024;
    localparam int RUN_CNT_W           = 16;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant, searching upward from ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import dispatch_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int w_j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        w_j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = int'(ptr) + k;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            if (!any && valid[w_j]) begin
                any        = 1'b1;
                grant[w_j] = 1'b1;
                grant_idx  = IDX_W'(w_j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/kernel_dispatch_arbiter.sv
// ============================================================================
// Module      : kernel_dispatch_arbiter
// Description : Round-robin sharing of one fib kernel among NUM_REQ clients.
//               Optional watchdog abort enabled by macro DISPATCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kernel_dispatch_arbiter
    import dispatch_pkg::*;
#(
    parameter int NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int N_W         = DEFAULT_N_W,
    parameter int D_W         = DEFAULT_D_W,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*N_W-1:0] req_n,
    input  logic [NUM_REQ*D_W-1:0] req_a,
    input  logic [NUM_REQ*D_W-1:0] req_b,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [D_W-1:0]         rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   k_r_enable,
    output logic                   k_control_arr,
    output logic [N_W-1:0]         k_init_n,
    output logic [D_W-1:0]         k_init_a,
    output logic [D_W-1:0]         k_init_b,
    input  logic                   k_w_enable,
    input  logic [D_W-1:0]         k_result
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
        $error("kernel_dispatch_arbiter: parameter out of range");
    end

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [N_W-1:0]     r_n;
    logic [D_W-1:0]     r_a;
    logic [D_W-1:0]     r_b;
    logic [D_W-1:0]     r_rsp_data;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_any;
    logic               w_hs;
    logic               w_timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .valid     (req_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    assign w_hs = (r_state == S_IDLE) && w_any;

`ifdef DISPATCH_TIMEOUT_EN
    logic [RUN_CNT_W-1:0] r_run_cnt;
    logic                 r_rsp_err;

    assign w_timeout = (r_run_cnt == RUN_CNT_W'(TIMEOUT_CYC - 1));
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cnt <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state == S_LAUNCH) begin
                r_run_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_run_cnt <= r_run_cnt + 1'b1;
            end
            // Done wins over a watchdog expiry in the same cycle.
            if (r_state == S_RUN) begin
                if (k_w_enable) begin
                    r_rsp_err <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_err <= 1'b1;
                end
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_RUN;
            S_RUN:    if (k_w_enable || w_timeout) w_next = S_RESP;
            S_RESP:   if (rsp_ready[r_grant_idx]) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_n         <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (w_hs) begin
                r_grant_idx <= w_grant_idx;
                r_n         <= req_n[w_grant_idx*N_W +: N_W];
                r_a         <= req_a[w_grant_idx*D_W +: D_W];
                r_b         <= req_b[w_grant_idx*D_W +: D_W];
                r_rr_ptr    <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
            end
            if (r_state == S_RUN) begin
                if (k_w_enable) begin
                    r_rsp_data <= k_result;
                end else if (w_timeout) begin
                    r_rsp_data <= '1;
                end
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (r_state == S_RESP) begin
            rsp_valid[r_grant_idx] = 1'b1;
        end
    end

    assign req_ready     = (r_state == S_IDLE) ? w_grant : '0;
    assign rsp_data      = r_rsp_data;
    assign busy          = (r_state != S_IDLE);
    assign k_r_enable    = (r_state == S_LAUNCH);
    assign k_control_arr = 1'b0;
    assign k_init_n      = r_n;
    assign k_init_a      = r_a;
    assign k_init_b      = r_b;

endmodule

`default_nettype wire

// File: tb/tb_kernel_dispatch_arbiter.sv
// ============================================================================
// Module      : tb_kernel_dispatch_arbiter
// Description : Directed bench with a behavioural fib kernel stand-in.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kernel_dispatch_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int N_W         = 6;
    localparam int D_W         = 32;
    localparam int TIMEOUT_CYC = 8;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*N_W-1:0] req_n;
    logic [NUM_REQ*D_W-1:0] req_a;
    logic [NUM_REQ*D_W-1:0] req_b;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [NUM_REQ-1:0]     rsp_ready;
    logic [D_W-1:0]         rsp_data;
    logic                   rsp_err;
    logic                   busy;
    logic                   k_r_enable;
    logic                   k_control_arr;
    logic [N_W-1:0]         k_init_n;
    logic [D_W-1:0]         k_init_a;
    logic [D_W-1:0]         k_init_b;
    logic                   k_w_enable = 1'b0;
    logic [D_W-1:0]         k_result   = '0;

    int n_vec     = 0;
    int n_bad     = 0;
    int pulse_cnt = 0;
    int k_lat     = 3;
    bit k_stall   = 1'b0;

    logic [N_W-1:0] arg_n [NUM_REQ];
    logic [D_W-1:0] arg_a [NUM_REQ];
    logic [D_W-1:0] arg_b [NUM_REQ];

    typedef struct {
        int             id;
        logic [N_W-1:0] n;
        logic [D_W-1:0] a;
        logic [D_W-1:0] b;
        logic [D_W-1:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    kernel_dispatch_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .N_W         (N_W),
        .D_W         (D_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_n         (req_n),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .k_r_enable    (k_r_enable),
        .k_control_arr (k_control_arr),
        .k_init_n      (k_init_n),
        .k_init_a      (k_init_a),
        .k_init_b      (k_init_b),
        .k_w_enable    (k_w_enable),
        .k_result      (k_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [D_W-1:0] fib(input logic [N_W-1:0] n, input logic [D_W-1:0] a, input logic [D_W-1:0] b);
        logic [D_W-1:0] x, y, t;
        x = a;
        y = b;
        for (int i = 0; i < int'(n); i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Kernel stand-in: clears done when started, raises it k_lat edges later.
    logic [N_W-1:0] m_n;
    logic [D_W-1:0] m_a, m_b;
    int             m_cnt = 0;
    bit             m_run = 1'b0;

    always @(posedge clk) begin
        if (k_r_enable) begin
            m_n        <= k_init_n;
            m_a        <= k_init_a;
            m_b        <= k_init_b;
            m_cnt      <= k_lat;
            m_run      <= 1'b1;
            k_w_enable <= 1'b0;
        end else if (m_run && !k_stall) begin
            if (m_cnt <= 1) begin
                k_w_enable <= 1'b1;
                k_result   <= fib(m_n, m_a, m_b);
                m_run      <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (k_r_enable) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [N_W-1:0] n, input logic [D_W-1:0] a, input logic [D_W-1:0] b);
        arg_n[id] = n;
        arg_a[id] = a;
        arg_b[id] = b;
        req_n[id*N_W +: N_W] = n;
        req_a[id*D_W +: D_W] = a;
        req_b[id*D_W +: D_W] = b;
        req_valid[id] = 1'b1;
    endtask

    // Called at a falling edge with the requests already presented.
    task automatic serve(input int id, input logic [D_W-1:0] exp_data, input logic exp_err,
                         input int exp_lat, input int hold);
        int t;
        int p0;
        bit stable;
        logic [NUM_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        #1;
        t = 0;
        while (req_ready == '0 && t < 50) begin
            @(negedge clk); #1;
            t++;
        end
        chk("grant", req_ready, oh);
        p0 = pulse_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid[id] = 1'b0;
        chk("launch_pulse", k_r_enable, 1);
        chk("init_n", k_init_n, arg_n[id]);
        chk("init_a", k_init_a, arg_a[id]);
        chk("init_b", k_init_b, arg_b[id]);
        chk("busy_launch", busy, 1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (rsp_valid == '0 && t < 200);
        chk("latency", t, exp_lat);
        chk("rsp_valid", rsp_valid, oh);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", rsp_err, exp_err);
        chk("pulse_count", pulse_cnt - p0, 1);
        stable    = 1'b1;
        rsp_ready = ~oh;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (rsp_valid !== oh || rsp_data !== exp_data || req_ready !== '0 || busy !== 1'b1)
                stable = 1'b0;
        end
        if (hold > 0) chk("hold_stable", stable, 1);
        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = '0;
        chk("rsp_drop", rsp_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bit seen;
        vecs[0] = '{0, 6'd10, 32'd0, 32'd1, 32'd55};
        vecs[1] = '{1, 6'd0,  32'd7, 32'd9, 32'd7};
        vecs[2] = '{2, 6'd2,  32'd3, 32'd4, 32'd7};
        vecs[3] = '{1, 6'd6,  32'd0, 32'd1, 32'd8};
        vecs[4] = '{0, 6'd1,  32'd5, 32'd6, 32'd6};
        vecs[5] = '{3, 6'd7,  32'd0, 32'd1, 32'd13};

        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_n     = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_k_r_enable", k_r_enable, 0);
        chk("rst_init_n", k_init_n, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_req(vecs[i].id, vecs[i].n, vecs[i].a, vecs[i].b);
            serve(vecs[i].id, vecs[i].exp_data, 1'b0, 5, 0);
        end

        // All four contend with rr_ptr at 0.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, N_W'(i + 1), 32'd0, 32'd1);
        serve(0, 32'd1, 1'b0, 5, 0);
        serve(1, 32'd1, 1'b0, 5, 0);
        serve(2, 32'd2, 1'b0, 5, 0);
        serve(3, 32'd3, 1'b0, 5, 0);

        // Single job moves rr_ptr to 2, so the next burst starts at 2.
        set_req(1, 6'd3, 32'd0, 32'd1);
        serve(1, 32'd2, 1'b0, 5, 0);
        for (int i = 0; i < NUM_REQ; i++) set_req(i, N_W'(i + 1), 32'd0, 32'd1);
        serve(2, 32'd2, 1'b0, 5, 0);
        serve(3, 32'd3, 1'b0, 5, 0);
        serve(0, 32'd1, 1'b0, 5, 0);
        serve(1, 32'd1, 1'b0, 5, 0);

        // Backpressure with another requester waiting.
        set_req(2, 6'd4, 32'd0, 32'd1);
        set_req(0, 6'd3, 32'd0, 32'd1);
        serve(2, 32'd3, 1'b0, 5, 20);
        serve(0, 32'd2, 1'b0, 5, 0);

        // Reset in the middle of a long run.
        k_lat = 30;
        set_req(1, 6'd20, 32'd0, 32'd1);
        #1;
        chk("rr_grant_pre_reset", req_ready, 4'b0010);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_run", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_k_r_enable", k_r_enable, 0);
        chk("async_rsp_valid", rsp_valid, 0);
        chk("async_rsp_data", rsp_data, 0);
        chk("async_init_n", k_init_n, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid !== '0 || busy !== 1'b0) seen = 1'b1;
        end
        chk("no_rsp_after_reset", seen, 0);
        k_lat = 3;
        set_req(0, 6'd5, 32'd0, 32'd1);
        serve(0, 32'd5, 1'b0, 5, 0);

`ifdef DISPATCH_TIMEOUT_EN
        k_stall = 1'b1;
        set_req(3, 6'd1, 32'd0, 32'd1);
        serve(3, 32'hFFFF_FFFF, 1'b1, TIMEOUT_CYC + 1, 0);
        k_stall = 1'b0;
        set_req(0, 6'd4, 32'd0, 32'd1);
        serve(0, 32'd3, 1'b0, 5, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/kernel_dispatch_arbiter.md
Name: kernel_dispatch_arbiter

Overview:
Shares one instance of the synthesized fib kernel (`main`: r_enable start, w_enable done, 32-bit result) between NUM_REQ requesters. It arbitrates requests round-robin and captures the winner's arguments. It then launches the kernel with a one-cycle r_enable pulse, waits for w_enable, and returns the result to the winning requester over a valid/ready response channel. It sits between client logic and the kernel; the kernel has no reset of its own, so this block owns all sequencing.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
N_W, 6, width of the n argument
D_W, 32, width of the a/b arguments and the result
TIMEOUT_CYC, 1024, watchdog limit in RUN cycles (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_n  in  NUM_REQ*N_W  packed n arguments; slice i belongs to requester i
req_a  in  NUM_REQ*D_W  packed a arguments
req_b  in  NUM_REQ*D_W  packed b arguments
rsp_valid  out  NUM_REQ  per-requester response valid, one-hot or zero
rsp_ready  in  NUM_REQ  per-requester response accept
rsp_data  out  D_W  result for the requester whose rsp_valid is set
rsp_err  out  1  response is a watchdog abort
busy  out  1  high in any state other than IDLE
k_r_enable  out  1  kernel start; high only in LAUNCH
k_control_arr  out  1  kernel controlArr; tied 0
k_init_n  out  N_W  kernel n argument, from capture register
k_init_a  out  D_W  kernel a argument, from capture register
k_init_b  out  D_W  kernel b argument, from capture register
k_w_enable  in  1  kernel done
k_result  in  D_W  kernel result, valid while k_w_enable is high

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, and all capture registers are 0.
  - req_ready, rsp_valid, rsp_err, busy and k_r_enable are all 0; rsp_data=0.
- k_w_enable is ignored outside RUN. The kernel is not reset by rst_n, and its w_enable is undefined before its first start.
- FSM IDLE -> LAUNCH -> RUN -> RESP -> IDLE.
- IDLE:
  - grant = first requester with req_valid set, searching from rr_ptr upward with wrap-around.
  - req_ready[grant]=1 combinationally; all other bits are 0. No valid request means req_ready=0.
  - On handshake: capture req_n/a/b[grant] and grant_idx, set rr_ptr to (grant+1) mod NUM_REQ, go to LAUNCH.
- LAUNCH: exactly one cycle with k_r_enable=1; k_init_* are driven from the capture registers; then go to RUN.
- RUN:
  - k_r_enable=0.
  - On the first cycle with k_w_enable=1: rsp_data<=k_result, rsp_err<=0, go to RESP.
  - The kernel clears w_enable on the LAUNCH edge, so a stale done is never seen.
- RESP:
  - rsp_valid[grant_idx]=1 and rsp_data is held stable until rsp_ready[grant_idx]=1; then go to IDLE.
  - rsp_ready bits of other requesters are ignored.
- Latency and throughput:
  - Request accepted at edge t: k_r_enable is high in cycle t+1, and RUN starts at t+2.
  - The response is visible the cycle after done is sampled.
  - Minimum occupancy is 4 + kernel run cycles; jobs never overlap.
- Simultaneous requests: one winner per job. A requester that keeps req_valid high is served at most once per NUM_REQ grants while others are waiting.
- A requester is allowed to drop req_valid before it is granted; no request is lost once req_ready has been seen.
- Reset mid-operation returns to IDLE immediately. The in-flight job is dropped with no response, and any kernel activity is ignored until the next LAUNCH.

Optional Feature:
DISPATCH_TIMEOUT_EN
- Defined:
  - A 16-bit run counter clears in LAUNCH and increments every RUN cycle.
  - If it reaches TIMEOUT_CYC before k_w_enable, go to RESP with rsp_data='1 and rsp_err=1.
  - The next LAUNCH restarts the kernel.
- Not defined: no counter; rsp_err is tied 0 and RUN waits indefinitely.

Decomposition:
- dispatch_pkg: state_t enum (IDLE, LAUNCH, RUN, RESP), widths and the default TIMEOUT_CYC constant.
- One sub-module, rr_arbiter: NUM_REQ inputs, combinational grant from valid and pointer, plus grant_idx output.

Test Plan:
- Single job: requester 0, n=10, a=0, b=1 -> k_r_enable high exactly one cycle; rsp_valid=0001, rsp_data=55, rsp_err=0.
- Zero iterations: n=0, a=7, b=9 -> rsp_data=7.
- Round-robin: all four requesters valid at once with n=1..4, a=0, b=1 -> grant order 0,1,2,3; results 1,1,2,3. A second burst starts again from rr_ptr.
- Response backpressure: hold rsp_ready low for 20 cycles -> rsp_valid and rsp_data stay stable; no req_ready pulses; busy=1 throughout.
- Reset during RUN: drop rst_n mid-job -> outputs go to 0 asynchronously; after release, a new job n=5, a=0, b=1 returns 5.
- With DISPATCH_TIMEOUT_EN and TIMEOUT_CYC=8: a stub kernel that never asserts done -> after 8 RUN cycles, rsp_err=1 and rsp_data=32'hFFFFFFFF.
